// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between an instruction-fetch port and a data port.
// Optional macro MEM_ARB_RR_EN selects round-robin tie-breaking; undefined means fixed D-port priority.
module mem_arbiter #(
    parameter int WORD_LEN = 32,
    parameter int RD_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [WORD_LEN-1:0] i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [WORD_LEN-1:0] i_rdata,
    input  logic                d_req,
    input  logic [WORD_LEN-1:0] d_addr,
    input  logic                d_wen,
    input  logic [WORD_LEN-1:0] d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [WORD_LEN-1:0] d_rdata,
    output logic                m_en,
    output logic                m_wen,
    output logic [WORD_LEN-1:0] m_addr,
    output logic [WORD_LEN-1:0] m_wdata,
    input  logic [WORD_LEN-1:0] m_rdata,
    output logic [1:0]          o_dbg_state
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("mem_arbiter: RD_LAT must be in 1..4");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    state_t              r_state;
    logic [2:0]          r_cnt;
    logic                r_port_d;
    logic                r_wen;
    logic                r_m_en;
    logic                r_m_wen;
    logic [WORD_LEN-1:0] r_m_addr;
    logic [WORD_LEN-1:0] r_m_wdata;
    logic                r_i_rvalid;
    logic                r_d_rvalid;
    logic [WORD_LEN-1:0] r_i_rdata;
    logic [WORD_LEN-1:0] r_d_rdata;
    logic                w_take;
    logic                w_pick_d;

    // Handshake: a requester holds req and payload until it sees gnt in the same cycle;
    // gnt is only given in IDLE, and the payload is captured on that clock edge.
`ifdef MEM_ARB_RR_EN
    logic r_last_d;

    always_comb begin
        w_pick_d = d_req;
        if (i_req && d_req) begin
            w_pick_d = ~r_last_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d <= 1'b1;
        end else if (w_take) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    assign w_pick_d = d_req;
`endif

    assign w_take = (r_state == S_IDLE) && (i_req || d_req) && !rst;
    assign i_gnt  = w_take && !w_pick_d;
    assign d_gnt  = w_take && w_pick_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_port_d   <= 1'b0;
            r_wen      <= 1'b0;
            r_m_en     <= 1'b0;
            r_m_wen    <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_m_en     <= 1'b0;
            r_m_wen    <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_state  <= S_ACCESS;
                        r_port_d <= w_pick_d;
                        r_wen    <= w_pick_d & d_wen;
                        r_m_en   <= 1'b1;
                        r_m_wen  <= w_pick_d & d_wen;
                        r_m_addr <= w_pick_d ? d_addr : i_addr;
                        if (w_pick_d) begin
                            r_m_wdata <= d_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    // Writes complete immediately; reads wait out the RAM latency.
                    if (r_wen) begin
                        r_state    <= S_DONE;
                        r_d_rvalid <= 1'b1;
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= 3'(RD_LAT);
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= S_DONE;
                        if (r_port_d) begin
                            r_d_rdata  <= m_rdata;
                            r_d_rvalid <= 1'b1;
                        end else begin
                            r_i_rdata  <= m_rdata;
                            r_i_rvalid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign m_en        = r_m_en;
    assign m_wen       = r_m_wen;
    assign m_addr      = r_m_addr;
    assign m_wdata     = r_m_wdata;
    assign i_rvalid    = r_i_rvalid;
    assign d_rvalid    = r_d_rvalid;
    assign i_rdata     = r_i_rdata;
    assign d_rdata     = r_d_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RD_LAT=1 instance with random and directed traffic, plus an RD_LAT=3 instance.
// Honours MEM_ARB_RR_EN in its reference model so it matches either build of the design.
module tb_mem_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk;
    logic        rst;

    // RD_LAT=1 instance
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_wen, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_en, m_wen;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  dbg0;

    // RD_LAT=3 instance
    logic        i_req3, i_gnt3, i_rvalid3;
    logic [31:0] i_addr3, i_rdata3;
    logic        d_req3, d_wen3, d_gnt3, d_rvalid3;
    logic [31:0] d_addr3, d_wdata3, d_rdata3;
    logic        m_en3, m_wen3;
    logic [31:0] m_addr3, m_wdata3, m_rdata3;
    logic [1:0]  dbg3;

    int n_cmp = 0;
    int n_fail = 0;

    mem_arbiter #(.WORD_LEN(32), .RD_LAT(LAT0)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .o_dbg_state(dbg0)
    );

    mem_arbiter #(.WORD_LEN(32), .RD_LAT(LAT1)) u_dut3 (
        .clk(clk), .rst(rst),
        .i_req(i_req3), .i_addr(i_addr3), .i_gnt(i_gnt3), .i_rvalid(i_rvalid3), .i_rdata(i_rdata3),
        .d_req(d_req3), .d_addr(d_addr3), .d_wen(d_wen3), .d_wdata(d_wdata3),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .m_en(m_en3), .m_wen(m_wen3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata3),
        .o_dbg_state(dbg3)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory macro models ----------------
    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a + 32'd3;
    endfunction

    logic [31:0] mem0 [1024];
    logic [31:0] pipe0 [LAT0];
    bit          pv0 [LAT0];
    logic [31:0] junk0;

    initial begin
        for (int k = 0; k < 1024; k++) mem0[k] = init_val(32'(k) << 2);
    end

    always @(posedge clk) begin
        junk0 <= $urandom;
        for (int k = LAT0 - 1; k > 0; k--) begin
            pipe0[k] <= pipe0[k-1];
            pv0[k]   <= pv0[k-1];
        end
        pv0[0]   <= m_en && !m_wen;
        pipe0[0] <= mem0[m_addr[11:2]];
        if (m_en && m_wen) mem0[m_addr[11:2]] <= m_wdata;
    end
    assign m_rdata = pv0[LAT0-1] ? pipe0[LAT0-1] : junk0;

    logic [31:0] pipe3 [LAT1];
    bit          pv3 [LAT1];
    logic [31:0] junk3;

    always @(posedge clk) begin
        junk3 <= $urandom;
        for (int k = LAT1 - 1; k > 0; k--) begin
            pipe3[k] <= pipe3[k-1];
            pv3[k]   <= pv3[k-1];
        end
        pv3[0]   <= m_en3 && !m_wen3;
        pipe3[0] <= init_val(m_addr3);
    end
    assign m_rdata3 = pv3[LAT1-1] ? pipe3[LAT1-1] : junk3;

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;
    bit          ref_last_d;
    logic [31:0] addr_pool [4] = '{32'h10, 32'h100, 32'h104, 32'h200};

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_i_gnt"}, i_gnt, 0);
        chk({tag, "_d_gnt"}, d_gnt, 0);
        chk({tag, "_i_rvalid"}, i_rvalid, 0);
        chk({tag, "_d_rvalid"}, d_rvalid, 0);
        chk({tag, "_i_rdata"}, i_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_m_en"}, m_en, 0);
        chk({tag, "_m_wen"}, m_wen, 0);
        chk({tag, "_m_addr"}, m_addr, 0);
        chk({tag, "_m_wdata"}, m_wdata, 0);
    endtask

    // ---------------- driver: one or two simultaneous requests on the RD_LAT=1 instance ----------------
    task automatic run_pair(input bit do_i, input logic [31:0] ia, input bit do_d,
                            input bit dw, input logic [31:0] da, input logic [31:0] dd);
        int g_i, g_d, r_i, r_d, n_men, n_irv, n_drv, last;
        logic [31:0] e_i, e_d;
        bit e_first_d;
        g_i = -1; g_d = -1; r_i = -1; r_d = -1;
        n_men = 0; n_irv = 0; n_drv = 0;
        if (do_i && do_d) begin
`ifdef MEM_ARB_RR_EN
            e_first_d = !ref_last_d;
`else
            e_first_d = 1'b1;
`endif
            ref_last_d = !e_first_d;
        end else begin
            e_first_d = do_d;
            ref_last_d = do_d;
        end
        // Memory effects in the order the accesses are expected to be granted.
        e_i = exp_i_rdata;
        e_d = exp_d_rdata;
        if (do_i && !e_first_d) e_i = ref_rd(ia);
        if (do_d) begin
            if (dw) ref_mem[da] = dd;
            else e_d = ref_rd(da);
        end
        if (do_i && e_first_d) e_i = ref_rd(ia);
        exp_i_rdata = e_i;
        exp_d_rdata = e_d;

        i_req = do_i; i_addr = ia;
        d_req = do_d; d_wen = dw; d_addr = da; d_wdata = dd;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            chk("gnt_excl", {31'd0, i_gnt & d_gnt}, 0);
            if (i_gnt && g_i < 0) g_i = cyc;
            if (d_gnt && g_d < 0) g_d = cyc;
            if (m_en) begin
                n_men++;
                if (g_d >= 0 && g_d == cyc - 1) begin
                    chk("m_addr_d", m_addr, da);
                    chk("m_wen_d", {31'd0, m_wen}, {31'd0, dw});
                    if (dw) chk("m_wdata_d", m_wdata, dd);
                end else begin
                    chk("m_addr_i", m_addr, ia);
                    chk("m_wen_i", {31'd0, m_wen}, 0);
                end
            end
            if (i_rvalid) begin
                n_irv++;
                if (r_i < 0) r_i = cyc;
                chk("i_rdata", i_rdata, e_i);
            end
            if (d_rvalid) begin
                n_drv++;
                if (r_d < 0) r_d = cyc;
                chk("d_rdata", d_rdata, e_d);
            end
            @(posedge clk);
            #1;
            // Payload after gnt must be ignored: scramble it when dropping req.
            if (g_i == cyc) begin i_req = 1'b0; i_addr = $urandom; end
            if (g_d == cyc) begin d_req = 1'b0; d_addr = $urandom; d_wdata = $urandom; d_wen = 1'($urandom); end
            last = (r_i > r_d) ? r_i : r_d;
            if ((!do_i || r_i >= 0) && (!do_d || r_d >= 0) && cyc >= last + 2) break;
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("n_m_en", n_men, 32'(int'(do_i) + int'(do_d)));
        chk("n_i_rvalid", n_irv, {31'd0, do_i});
        chk("n_d_rvalid", n_drv, {31'd0, do_d});
        if (do_i) chk("i_latency", r_i - g_i, LAT0 + 2);
        if (do_d) chk("d_latency", r_d - g_d, dw ? 2 : LAT0 + 2);
        if (do_i && do_d) begin
            chk("tie_first_d", {31'd0, g_d < g_i}, {31'd0, e_first_d});
            chk("second_gnt_gap", e_first_d ? g_i - r_d : g_d - r_i, 1);
        end
        chk("i_rdata_hold", i_rdata, exp_i_rdata);
        chk("d_rdata_hold", d_rdata, exp_d_rdata);
    endtask

    // ---------------- RD_LAT=3 read ----------------
    task automatic run_read3(input logic [31:0] a);
        int g, r, nrv, ndrv;
        g = -1; r = -1; nrv = 0; ndrv = 0;
        i_req3 = 1'b1; i_addr3 = a;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (i_gnt3 && g < 0) g = c;
            if (i_rvalid3) begin nrv++; if (r < 0) r = c; end
            if (d_rvalid3) ndrv++;
            @(posedge clk);
            #1;
            if (g == c) begin i_req3 = 1'b0; i_addr3 = $urandom; end
        end
        chk("lat3_gnt_cycle", g, 0);
        chk("lat3_latency", r - g, LAT1 + 2);
        chk("lat3_n_rvalid", nrv, 1);
        chk("lat3_d_rvalid", ndrv, 0);
        chk("lat3_i_rdata", i_rdata3, init_val(a));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234;
        i_req3 = 1'b0; i_addr3 = '0;
        d_req3 = 1'b0; d_wen3 = 1'b0; d_addr3 = '0; d_wdata3 = '0;
        exp_i_rdata = '0; exp_d_rdata = '0; ref_last_d = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_state", {30'd0, dbg0}, 0);
        @(posedge clk);
        #1;
        i_req = 1'b0; d_req = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Instruction fetch of 0x10 (memory holds 0x13 there).
        run_pair(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("t1_i_rdata", i_rdata, 32'h13);

        // Data write then read-back.
        run_pair(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
        run_pair(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
        chk("t2_readback", d_rdata, 32'hDEADBEEF);

        // Simultaneous requests, then three back-to-back ties.
        run_pair(1'b1, 32'h104, 1'b1, 1'b0, 32'h200, 32'h0);
        for (int t = 0; t < 3; t++) begin
            run_pair(1'b1, addr_pool[t], 1'b1, 1'($urandom), addr_pool[3-t], $urandom);
        end

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            bit ri, rd;
            ri = 1'($urandom);
            rd = 1'($urandom);
            if (!ri && !rd) rd = 1'b1;
            run_pair(ri, addr_pool[$urandom_range(0, 3)], rd, 1'($urandom),
                     addr_pool[$urandom_range(0, 3)], $urandom);
        end

        // Make both rdata registers nonzero, then reset in the WAIT cycle of a read.
        run_pair(1'b1, 32'h10, 1'b1, 1'b0, 32'h104, 32'h0);
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h104;
        @(negedge clk);
        chk("rst_test_d_gnt", {31'd0, d_gnt}, 1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_test_in_wait", {30'd0, dbg0}, 2);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_d_rvalid", {31'd0, d_rvalid}, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_i_rdata = '0; exp_d_rdata = '0; ref_last_d = 1'b1;
        for (int n = 0; n < 2; n++) @(negedge clk);
        chk("post_rst_no_rvalid", {30'd0, i_rvalid, d_rvalid}, 0);
        @(posedge clk);
        #1;
        run_pair(1'b1, 32'h200, 1'b1, 1'b0, 32'h104, 32'h0);

        // RD_LAT=3: rvalid five cycles after gnt, early garbage on m_rdata ignored.
        run_read3(32'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and data port.
- Accepts one request at a time through a req/gnt handshake, sequences the memory access and waits out the fixed read latency.
- Returns a registered response with an rvalid pulse to the port that issued the request.
- Sits between the core's ImemPort/DmemPort and the memory macro, so instructions and data can live in one physical RAM.

Parameters:
- WORD_LEN, 32, width of address and data buses.
- RD_LAT, 1, cycles from m_en to valid m_rdata. Legal range 1..4; any other value is a configuration error.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction read request.
- i_addr  in  WORD_LEN  instruction address.
- i_gnt  out  1  instruction request accepted this cycle.
- i_rvalid  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  WORD_LEN  fetched instruction, held.
- d_req  in  1  data request.
- d_addr  in  WORD_LEN  data address.
- d_wen  in  1  1 = write, 0 = read.
- d_wdata  in  WORD_LEN  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse: read data valid, or write done.
- d_rdata  out  WORD_LEN  load data, held.
- m_en  out  1  memory access strobe.
- m_wen  out  1  memory write enable.
- m_addr  out  WORD_LEN  memory address.
- m_wdata  out  WORD_LEN  memory write data.
- m_rdata  in  WORD_LEN  memory read data.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE, counter = 0, last_grant = D. All outputs are 0, including i_rdata, d_rdata, m_addr and m_wdata. An in-flight access is abandoned with no rvalid and no write.
- States:
  - IDLE: if any req is high, i_gnt/d_gnt is asserted combinationally for the selected port (Mealy output). On that edge, port id, address, wen and wdata are latched and the FSM moves to ACCESS. With no req it stays in IDLE.
  - ACCESS (1 cycle): m_en = 1. m_wen = latched wen, which is only possible for the D port. m_addr and m_wdata come from the latch. Next state: write -> DONE; read -> WAIT with counter = RD_LAT.
  - WAIT: counter decrements each cycle. In the cycle where counter == 1, m_rdata is captured into the rdata register of the issuing port, and the FSM goes to DONE.
  - DONE (1 cycle): the issuing port's rvalid = 1. For a write, d_rvalid = 1 and d_rdata is unchanged. Next state is IDLE.
- Latency (gnt in cycle 0):
  - Read: rvalid in cycle RD_LAT+2.
  - Write: d_rvalid in cycle 2.
  - No overlap: the next gnt comes no earlier than the cycle after DONE.
- m_en and m_wen are 0 outside ACCESS. m_addr and m_wdata hold their latched values between accesses.
- rdata registers hold until the next response to the same port. The other port's rdata is never disturbed.
- A requester holds req and its payload until it sees gnt. Dropping req before gnt is legal and no access happens. Payload changes after gnt are ignored.
- When both ports request in IDLE, the D port wins. The I port waits, holding req.
- A req that rises while the FSM is not in IDLE gets no gnt until the FSM is back in IDLE.
- Address is passed through unmodified; there is no alignment check.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On a tie, grant the port that is not last_grant. last_grant updates on every gnt and resets to D, so the first tie goes to I.
- Undefined: fixed priority, D always wins ties. The last_grant register is not implemented.

Test Plan:
- RD_LAT=1. i_req=1, i_addr=0x0000_0010, memory holds 0x0000_0013 there -> i_gnt in cycle 0, m_en in cycle 1 with m_addr=0x10, i_rvalid in cycle 3 with i_rdata=0x0000_0013; d_rvalid stays 0.
- d_req=1, d_wen=1, d_addr=0x100, d_wdata=0xDEADBEEF -> m_en=m_wen=1 in cycle 1 with that address/data, d_rvalid in cycle 2, d_rdata unchanged. A following read of 0x100 returns 0xDEADBEEF.
- i_req and d_req both high in the same cycle, macro off -> d_gnt first. i_gnt comes in the cycle after d's DONE. Exactly two m_en pulses in total.
- Macro on, three back-to-back ties -> grant order I, D, I.
- RD_LAT=3 read -> rvalid in cycle 5. Check that m_rdata garbage in cycles 2-3 is not captured.
- Assert rst in the WAIT cycle of a read -> all outputs 0 immediately, no rvalid. After release, a new request completes normally.
